s64x7_wb_narrow_bridge: RTL

//  Downstream of the S64X7 core bus port. Accepts one 64-bit core transfer (adr_i[63:3], sel_i[7:0])
//  and performs it as a locked burst of 16-bit Wishbone classic beats, one per active halfword lane.

---
 rtl/s64x7_wb_narrow_bridge_pkg.sv | 20 ++
 rtl/s64x7_wb_narrow_bridge_lane_pick.sv | 25 ++
 rtl/s64x7_wb_narrow_bridge.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/s64x7_wb_narrow_bridge_pkg.sv
// Shared constants for the S64X7 64-to-16-bit Wishbone bridge: FSM encodings,
// lane geometry and the fill pattern returned for a timed-out read beat.
package s64x7_wb_narrow_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BEAT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int          NLANES   = 4;
  localparam logic [15:0] TMO_FILL = 16'hFFFF;

  // A halfword lane is active when either of its two byte selects is set.
  function automatic logic [NLANES-1:0] lane_mask(input logic [7:0] sel);
    logic [NLANES-1:0] m;
    m = '0;
    for (int k = 0; k < NLANES; k++) m[k] = |sel[2*k +: 2];
    return m;
  endfunction

endpackage

// File: rtl/s64x7_wb_narrow_bridge_lane_pick.sv
// Lane selector: with first=1 returns the lowest set lane of mask, otherwise the
// next set lane strictly above cur; none flags that no such lane exists.
module s64x7_lane_pick
  import s64x7_wb_narrow_bridge_pkg::*;
(
  input  logic [3:0] mask,
  input  logic [1:0] cur,
  input  logic       first,
  output logic [1:0] next,
  output logic       none
);

  always_comb begin
    // NOTE: defaults before the search keep every path assigned, so no latch is inferred.
    next = '0;
    none = 1'b1;
    for (int k = NLANES - 1; k >= 0; k--) begin
      if (mask[k] && (first || (k > int'(cur)))) begin
        next = 2'(k);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/s64x7_wb_narrow_bridge.sv
// Splits one 64-bit core transfer into a locked burst of 16-bit Wishbone classic
// beats (one per active halfword lane) and returns a single ack to the core.
module s64x7_wb_narrow_bridge
  import s64x7_wb_narrow_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [60:0] adr_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [7:0]  sel_i,
  input  logic        we_i,
  input  logic        vpa_i,
  input  logic [63:0] dat_i,
  output logic        ack_o,
  output logic [63:0] dat_o,
  output logic        tmo_o,
  output logic [62:0] m_adr_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic [1:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_vpa_o,
  output logic [15:0] m_dat_o,
  input  logic [15:0] m_dat_i,
  input  logic        m_ack_i
);

  localparam logic       TMO_EN  = (TIMEOUT != 0);
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

  logic [1:0]  r_state;
  logic [60:0] r_adr;
  logic [7:0]  r_sel;
  logic        r_we;
  logic [63:0] r_dat;
  logic [3:0]  r_mask;
  logic [1:0]  r_lane;
  logic [63:0] r_buf;
  logic [7:0]  r_wait;

  logic        w_idle;
  logic [3:0]  w_pick_mask;
  logic [1:0]  w_next;
  logic        w_none;
  logic [60:0] w_lane_adr;
  logic [7:0]  w_lane_sel;
  logic [63:0] w_lane_dat;
  logic [7:0]  w_wait_inc;
  logic        w_tmo;
  logic        w_beat_done;
  logic [63:0] w_buf_upd;

  // In IDLE the picker looks at the incoming request; in BEAT at the latched one.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_pick_mask = w_idle ? lane_mask(sel_i) : r_mask;
  assign w_lane_adr  = w_idle ? adr_i : r_adr;
  assign w_lane_sel  = w_idle ? sel_i : r_sel;
  assign w_lane_dat  = w_idle ? dat_i : r_dat;

  s64x7_lane_pick u_lane_pick (
    .mask  (w_pick_mask),
    .cur   (r_lane),
    .first (w_idle),
    .next  (w_next),
    .none  (w_none)
  );

  // A real ack in the same cycle as the limit suppresses the timeout.
  assign w_wait_inc  = r_wait + 8'd1;
  assign w_tmo       = TMO_EN && (w_wait_inc == TMO_LIM) && !m_ack_i;
  assign w_beat_done = m_ack_i || w_tmo;

  always_comb begin
    w_buf_upd = r_buf;
    if (!r_we) w_buf_upd[{r_lane, 4'b0000} +: 16] = m_ack_i ? m_dat_i : TMO_FILL;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
      r_state <= ST_IDLE;
      r_adr   <= '0;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_dat   <= '0;
      r_mask  <= '0;
      r_lane  <= '0;
      r_buf   <= '0;
      r_wait  <= '0;
      ack_o   <= 1'b0;
      dat_o   <= '0;
      tmo_o   <= 1'b0;
      m_adr_o <= '0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_sel_o <= '0;
      m_we_o  <= 1'b0;
      m_vpa_o <= 1'b0;
      m_dat_o <= '0;
    end else begin
      ack_o <= 1'b0;
      tmo_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cyc_i && stb_i) begin
            r_adr   <= adr_i;
            r_sel   <= sel_i;
            r_we    <= we_i;
            r_dat   <= dat_i;
            r_mask  <= w_pick_mask;
            r_buf   <= '0;
            r_wait  <= '0;
            r_lane  <= w_next;
            m_vpa_o <= vpa_i;
            if (w_none) begin
              r_state <= ST_DONE;
              ack_o   <= 1'b1;
              dat_o   <= '0;
            end else begin
              r_state <= ST_BEAT;
              m_cyc_o <= 1'b1;
              m_stb_o <= 1'b1;
              m_we_o  <= we_i;
              m_adr_o <= {w_lane_adr, w_next};
              m_sel_o <= w_lane_sel[{w_next, 1'b0} +: 2];
              m_dat_o <= w_lane_dat[{w_next, 4'b0000} +: 16];
            end
          end
        end
        ST_BEAT: begin
          if (!cyc_i) begin
            r_state <= ST_IDLE;
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
          end else if (w_beat_done) begin
            r_buf  <= w_buf_upd;
            r_wait <= '0;
            tmo_o  <= w_tmo;
            if (w_none) begin
              r_state <= ST_DONE;
              ack_o   <= 1'b1;
              dat_o   <= w_buf_upd;
              m_cyc_o <= 1'b0;
              m_stb_o <= 1'b0;
              m_we_o  <= 1'b0;
            end else begin
              r_lane  <= w_next;
              m_adr_o <= {w_lane_adr, w_next};
              m_sel_o <= w_lane_sel[{w_next, 1'b0} +: 2];
              m_dat_o <= w_lane_dat[{w_next, 4'b0000} +: 16];
            end
          end else begin
            r_wait <= w_wait_inc;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
